// File: rtl/image_bbox_detect.sv
// image_bbox_detect
// Finds the inclusive bounding box and foreground count of a binary video
// frame. Results are registered with a one-cycle bbox_valid pulse on the cycle
// after vsync falls. If the count is below MIN_PIXELS, bbox_found is 0 and the
// coordinates read 0.
// Optional feature: define IMAGE_BBOX_OVERLAY_EN to add a one-cycle-delayed
// copy of the video stream with the previously reported box drawn onto it.
module image_bbox_detect #(
  parameter int IMG_HDISP  = 640,
  parameter int IMG_VDISP  = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,        // synchronous, active high
  input  logic        image_in_vsync,
  input  logic        image_in_href,
  input  logic        image_in_data,
`ifdef IMAGE_BBOX_OVERLAY_EN
  output logic        image_out_vsync,
  output logic        image_out_href,
  output logic        image_out_data,
`endif
  output logic        bbox_valid,
  output logic        bbox_found,
  output logic [11:0] bbox_xmin,
  output logic [11:0] bbox_xmax,
  output logic [11:0] bbox_ymin,
  output logic [11:0] bbox_ymax,
  output logic [19:0] bbox_count
);

  typedef enum logic [1:0] {WAIT_IDLE, WAIT_FRAME, IN_FRAME} state_t;

  localparam logic [11:0] CMAX = 12'hfff;
  localparam logic [19:0] NMAX = 20'hfffff;
  localparam logic [12:0] HLIM = 13'(IMG_HDISP);
  localparam logic [12:0] VLIM = 13'(IMG_VDISP);
  localparam logic [20:0] MINP = 21'(MIN_PIXELS);

  state_t      state, state_nxt;
  logic [11:0] x_cnt, y_cnt;
  logic        href_d;
  logic [11:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [19:0] acc_cnt;
  logic        in_frame, pix, fg, frame_start, frame_end, line_end, found_nxt;

  assign in_frame    = (state == IN_FRAME);
  assign pix         = in_frame & image_in_vsync & image_in_href;
  assign frame_start = (state == WAIT_FRAME) & image_in_vsync;
  assign frame_end   = in_frame & ~image_in_vsync;
  assign line_end    = in_frame & href_d & ~image_in_href;
  assign fg          = pix & image_in_data & ({1'b0, x_cnt} < HLIM) & ({1'b0, y_cnt} < VLIM);
  assign found_nxt   = ({1'b0, acc_cnt} >= MINP);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state <= WAIT_IDLE;
    else       state <= state_nxt;
  end

  // Next state: a frame only counts once a clean vsync low->high edge is seen
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE:  if (!image_in_vsync) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (image_in_vsync)  state_nxt = IN_FRAME;
      IN_FRAME:   if (!image_in_vsync) state_nxt = WAIT_FRAME;
      default:    state_nxt = WAIT_IDLE;
    endcase
  end

  // Pixel position counters (saturating); x restarts whenever href drops
  always_ff @(posedge clk) begin
    if (rst_n || frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (!image_in_href)            x_cnt <= '0;
      else if (pix && x_cnt != CMAX) x_cnt <= x_cnt + 12'd1;
      if (line_end && y_cnt != CMAX) y_cnt <= y_cnt + 12'd1;
    end
  end

  // Line-end detection needs the previous href level
  always_ff @(posedge clk) begin
    if (rst_n) href_d <= 1'b0;
    else       href_d <= image_in_href;
  end

  // Running box / count; cleared when a frame is reported or on reset
  always_ff @(posedge clk) begin
    if (rst_n || frame_end) begin
      acc_xmin <= CMAX;
      acc_xmax <= '0;
      acc_ymin <= CMAX;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (fg) begin
      if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
      if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
      if (y_cnt < acc_ymin) acc_ymin <= y_cnt;
      if (y_cnt > acc_ymax) acc_ymax <= y_cnt;
      if (acc_cnt != NMAX)  acc_cnt  <= acc_cnt + 20'd1;
    end
  end

  // Result registers: loaded at frame close, held until the next close
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bbox_valid <= 1'b0;
      bbox_found <= 1'b0;
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
      bbox_count <= '0;
    end else begin
      bbox_valid <= frame_end;
      if (frame_end) begin
        bbox_found <= found_nxt;
        bbox_xmin  <= found_nxt ? acc_xmin : 12'd0;
        bbox_xmax  <= found_nxt ? acc_xmax : 12'd0;
        bbox_ymin  <= found_nxt ? acc_ymin : 12'd0;
        bbox_ymax  <= found_nxt ? acc_ymax : 12'd0;
        bbox_count <= acc_cnt;
      end
    end
  end

`ifdef IMAGE_BBOX_OVERLAY_EN
  logic on_vedge, on_hedge;

  // The box drawn is the one currently on the outputs, i.e. the previous frame
  assign on_vedge = (x_cnt == bbox_xmin || x_cnt == bbox_xmax) &&
                    (y_cnt >= bbox_ymin) && (y_cnt <= bbox_ymax);
  assign on_hedge = (y_cnt == bbox_ymin || y_cnt == bbox_ymax) &&
                    (x_cnt >= bbox_xmin) && (x_cnt <= bbox_xmax);

  // One-cycle delayed video with the box border forced to foreground
  always_ff @(posedge clk) begin
    if (rst_n) begin
      image_out_vsync <= 1'b0;
      image_out_href  <= 1'b0;
      image_out_data  <= 1'b0;
    end else begin
      image_out_vsync <= image_in_vsync;
      image_out_href  <= image_in_href;
      image_out_data  <= image_in_data | (pix & bbox_found & (on_vedge | on_hedge));
    end
  end
`endif

endmodule

// File: tb/tb_image_bbox_detect.sv
// tb_image_bbox_detect
// Drives directed and random binary frames into two configurations of
// image_bbox_detect (full 640x480 and a tiny 20x10) and compares every report
// against a per-pixel model built from loop indices. With
// IMAGE_BBOX_OVERLAY_EN defined the overlay stream is checked too.
`timescale 1ns/1ps
module tb_image_bbox_detect;

  typedef struct {
    logic        found;
    logic [11:0] x0, x1, y0, y1;
    logic [19:0] cnt;
    int          at;
  } res_t;

  logic clk = 1'b0;
  logic rst_n, vs, hr, dt;
  logic        bv [2];
  logic        bf [2];
  logic [11:0] bx0[2], bx1[2], by0[2], by1[2];
  logic [19:0] bc [2];
`ifdef IMAGE_BBOX_OVERLAY_EN
  logic ov[2], oh[2], od[2];
`endif

  int total = 0, bad = 0, cyc = 0, close_cyc = 0;
  int ovl_bad = 0, ovl_ones = 0;
  int hd[2], vd[2], mn[2];
  int ax0[2], ax1[2], ay0[2], ay1[2], acnt[2];
  res_t last[2];
  res_t q0[$], q1[$];
  bit   rnd[0:15][0:31];

  always #5 clk = ~clk;

  image_bbox_detect u_big (
    .clk(clk), .rst_n(rst_n),
    .image_in_vsync(vs), .image_in_href(hr), .image_in_data(dt),
`ifdef IMAGE_BBOX_OVERLAY_EN
    .image_out_vsync(ov[0]), .image_out_href(oh[0]), .image_out_data(od[0]),
`endif
    .bbox_valid(bv[0]), .bbox_found(bf[0]),
    .bbox_xmin(bx0[0]), .bbox_xmax(bx1[0]), .bbox_ymin(by0[0]), .bbox_ymax(by1[0]),
    .bbox_count(bc[0])
  );

  image_bbox_detect #(.IMG_HDISP(20), .IMG_VDISP(10), .MIN_PIXELS(5)) u_small (
    .clk(clk), .rst_n(rst_n),
    .image_in_vsync(vs), .image_in_href(hr), .image_in_data(dt),
`ifdef IMAGE_BBOX_OVERLAY_EN
    .image_out_vsync(ov[1]), .image_out_href(oh[1]), .image_out_data(od[1]),
`endif
    .bbox_valid(bv[1]), .bbox_found(bf[1]),
    .bbox_xmin(bx0[1]), .bbox_xmax(bx1[1]), .bbox_ymin(by0[1]), .bbox_ymax(by1[1]),
    .bbox_count(bc[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Record every bbox_valid cycle, with the tick index it was seen in
  always @(negedge clk) begin
    res_t r;
    if (bv[0] === 1'b1) begin
      r.found = bf[0]; r.x0 = bx0[0]; r.x1 = bx1[0]; r.y0 = by0[0]; r.y1 = by1[0];
      r.cnt = bc[0]; r.at = cyc;
      q0.push_back(r);
    end
    if (bv[1] === 1'b1) begin
      r.found = bf[1]; r.x0 = bx0[1]; r.x1 = bx1[1]; r.y0 = by0[1]; r.y1 = by1[1];
      r.cnt = bc[1]; r.at = cyc;
      q1.push_back(r);
    end
  end

  function automatic bit border(input res_t b, input int x, input int y);
    return ((x == int'(b.x0) || x == int'(b.x1)) && y >= int'(b.y0) && y <= int'(b.y1)) ||
           ((y == int'(b.y0) || y == int'(b.y1)) && x >= int'(b.x0) && x <= int'(b.x1));
  endfunction

  function automatic bit pixval(input int kind, input int x, input int y);
    case (kind)
      0: return (x >= 100 && x <= 199 && y >= 50 && y <= 59);
      1: return (y == 3 && x >= 5 && x <= 14);
      2: return (y == 5 && (x == 700 || (x >= 10 && x <= 29)));
      3: return 1'b0;
      5: return (y == 0) ? (x >= 4096) : (y == 1 && x >= 10 && x <= 29);
      6: return 1'b1;
      default: return rnd[y][x];
    endcase
  endfunction

  // One clock: drive, step past the edge, check the overlay stream
  task automatic tick(input logic v, input logic h, input logic d,
                      input int xc, input int y, input bit is_pix);
    logic e;
    vs = v; hr = h; dt = d;
    @(posedge clk); #1;
    cyc++;
`ifdef IMAGE_BBOX_OVERLAY_EN
    for (int p = 0; p < 2; p++) begin
      e = rst_n ? 1'b0 : (d | (is_pix && last[p].found && border(last[p], xc, y)));
      if (od[p] !== e || ov[p] !== (rst_n ? 1'b0 : v) || oh[p] !== (rst_n ? 1'b0 : h))
        ovl_bad++;
      if (p == 0 && is_pix && od[p] === 1'b1) ovl_ones++;
    end
`else
    e = d & is_pix & (xc >= 0) & (y >= 0);
`endif
  endtask

  task automatic chk_outs(input string tag, input int p, input res_t e);
    chk($sformatf("%s_d%0d_found", tag, p), 32'(bf[p]), 32'(e.found));
    chk($sformatf("%s_d%0d_xmin", tag, p), 32'(bx0[p]), 32'(e.x0));
    chk($sformatf("%s_d%0d_xmax", tag, p), 32'(bx1[p]), 32'(e.x1));
    chk($sformatf("%s_d%0d_ymin", tag, p), 32'(by0[p]), 32'(e.y0));
    chk($sformatf("%s_d%0d_ymax", tag, p), 32'(by1[p]), 32'(e.y1));
    chk($sformatf("%s_d%0d_count", tag, p), 32'(bc[p]), 32'(e.cnt));
  endtask

  task automatic frame(input int kind, input int nl, input int ll,
                       input int rst_line, input bit abrupt);
    int   len, xm, n;
    bit   d, in_fr, rst_hit;
    res_t e, r, z;
    z = '{default: 0};
    // href activity with vsync low must be ignored
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      ax0[p] = 4095; ax1[p] = 0; ay0[p] = 4095; ay1[p] = 0; acnt[p] = 0;
    end
    in_fr = 1'b1; rst_hit = 1'b0; ovl_bad = 0; ovl_ones = 0;
    for (int y = 0; y < nl; y++) begin
      len = (kind == 2 && y == 5) ? 701 : (kind == 5 && y == 0) ? 4200 : ll;
      for (int x = 0; x < len; x++) begin
        d  = pixval(kind, x, y);
        xm = (x > 4095) ? 4095 : x;
        if (y == rst_line && x == 3) begin
          rst_n = 1'b1;
          tick(1'b1, 1'b1, d, xm, y, 1'b0);
          rst_n = 1'b0;
          in_fr = 1'b0; rst_hit = 1'b1;
          for (int p = 0; p < 2; p++) begin
            last[p] = z;
            chk_outs("midrst", p, z);
          end
        end else begin
          if (in_fr && d)
            for (int p = 0; p < 2; p++)
              if (xm < hd[p] && y < vd[p]) begin
                if (xm < ax0[p]) ax0[p] = xm;
                if (xm > ax1[p]) ax1[p] = xm;
                if (y < ay0[p])  ay0[p] = y;
                if (y > ay1[p])  ay1[p] = y;
                acnt[p]++;
              end
          tick(1'b1, 1'b1, d, xm, y, in_fr);
        end
      end
      if (!(abrupt && y == nl - 1))
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    tick(1'b0, abrupt, 1'b0, 0, 0, 1'b0);   // vsync falls (possibly mid-line)
    close_cyc = cyc;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    for (int p = 0; p < 2; p++) begin
      e.found = (acnt[p] >= mn[p]);
      e.x0  = e.found ? 12'(ax0[p]) : 12'd0;
      e.x1  = e.found ? 12'(ax1[p]) : 12'd0;
      e.y0  = e.found ? 12'(ay0[p]) : 12'd0;
      e.y1  = e.found ? 12'(ay1[p]) : 12'd0;
      e.cnt = 20'(acnt[p]);
      e.at  = close_cyc;
      n = (p == 0) ? q0.size() : q1.size();
      chk($sformatf("k%0d_d%0d_npulse", kind, p), 32'(n), rst_hit ? 32'd0 : 32'd1);
      if (!rst_hit && n > 0) begin
        if (p == 0) r = q0.pop_front(); else r = q1.pop_front();
        chk($sformatf("k%0d_d%0d_found", kind, p), 32'(r.found), 32'(e.found));
        chk($sformatf("k%0d_d%0d_xmin", kind, p), 32'(r.x0), 32'(e.x0));
        chk($sformatf("k%0d_d%0d_xmax", kind, p), 32'(r.x1), 32'(e.x1));
        chk($sformatf("k%0d_d%0d_ymin", kind, p), 32'(r.y0), 32'(e.y0));
        chk($sformatf("k%0d_d%0d_ymax", kind, p), 32'(r.y1), 32'(e.y1));
        chk($sformatf("k%0d_d%0d_count", kind, p), 32'(r.cnt), 32'(e.cnt));
        chk($sformatf("k%0d_d%0d_when", kind, p), 32'(r.at), 32'(close_cyc));
        last[p] = e;
      end
      if (p == 0) q0.delete(); else q1.delete();
      chk_outs($sformatf("k%0d_hold", kind), p, last[p]);
    end
`ifdef IMAGE_BBOX_OVERLAY_EN
    chk($sformatf("k%0d_ovl_bad", kind), 32'(ovl_bad), 32'd0);
    if (kind == 3) chk("ovl_border_pixels", 32'(ovl_ones), 32'd216);
`endif
  endtask

  initial begin
    res_t z;
    int   nl, ll, dens;
    z = '{default: 0};
    hd[0] = 640; vd[0] = 480; mn[0] = 16;
    hd[1] = 20;  vd[1] = 10;  mn[1] = 5;
    last[0] = z; last[1] = z;
    rst_n = 1'b1; vs = 1'b0; hr = 1'b0; dt = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rst_d%0d_valid", p), 32'(bv[p]), 32'd0);
      chk_outs("rst", p, z);
    end
    rst_n = 1'b0;

    frame(0, 60, 200, -1, 1'b0);   // 100..199 x 50..59 box
    frame(3, 60, 200, -1, 1'b0);   // empty frame, overlay shows the old box
    frame(1, 6, 30, -1, 1'b0);     // 10 pixels: below big MIN, above small MIN
    frame(2, 8, 40, -1, 1'b0);     // pixel beyond HDISP + 20-pixel run
    frame(5, 2, 30, -1, 1'b0);     // x counter saturation on a 4200-pixel line
    frame(6, 300, 8, 200, 1'b0);   // reset at line 200: no report
    frame(0, 60, 200, -1, 1'b1);   // next full frame, closed mid-line
    for (int k = 0; k < 12; k++) begin
      nl   = $urandom_range(3, 14);
      ll   = $urandom_range(4, 30);
      dens = $urandom_range(0, 3);
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 32; x++)
          rnd[y][x] = ($urandom_range(0, 3) < dens);
      frame(7, nl, ll, -1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
